// File: rtl/req_encoder_8to3_pkg.sv
// Shared definitions for the 8-to-3 request encoder: sizes, FSM states and
// the priority helper used to pick the highest pending request.
package req_encoder_8to3_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  // Any encoding not listed here is treated as IDLE by the FSM.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Highest set bit index wins; returns 0 for an empty vector (only meaningful with VALID).
  function automatic logic [CODE_W-1:0] highest_index(input logic [N_REQ-1:0] vec);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (vec[k]) begin
        idx = k[CODE_W-1:0];
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/req_encoder_8to3_sync_fall_det.sv
// Per-line synchronizer and falling-edge detector for one active-low request.
// All history flops reset to 1 (inactive). An arming shift register keeps the
// detector quiet until the prev flop holds a genuinely sampled value, so a line
// held low through reset release never produces a false fall.
module req_encoder_8to3_sync_fall_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req_n,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;
  logic [SYNC_STAGES:0]   armed_q;
  logic [SYNC_STAGES:0]   armed_d;

  // Shift the raw line through the synchronizer, remember the last synced value,
  // and fill the arming chain with ones after reset.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], req_n};
    prev_d  = sync_q[SYNC_STAGES-1];
    armed_d = {armed_q[SYNC_STAGES-1:0], 1'b1};
  end

  // History registers with asynchronous reset to the inactive level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '1;
      prev_q  <= 1'b1;
      armed_q <= '0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  assign fall = armed_q[SYNC_STAGES] & prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/req_encoder_8to3.sv
// Sequential 8-to-3 priority request encoder. Falling edges on the active-low
// request lines are latched as pending; the highest pending index is offered
// on {C,B,A} with a VALID/ACK handshake, followed by one idle gap cycle.
// GS_n/EO_n carry 74x148-style status and are registered alongside VALID.
module req_encoder_8to3
  import req_encoder_8to3_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EI_n,
  input  logic [N_REQ-1:0] I_n,
  input  logic             ACK,
  output logic             C,
  output logic             B,
  output logic             A,
  output logic             VALID,
  output logic             GS_n,
  output logic             EO_n,
  output logic [N_REQ-1:0] PEND
);

  logic [N_REQ-1:0]  fall;
  logic [N_REQ-1:0]  set_vec;
  logic [N_REQ-1:0]  clr_vec;
  logic [N_REQ-1:0]  pend_q;
  logic [N_REQ-1:0]  pend_d;
  state_e            state_q;
  state_e            state_d;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] code_d;
  logic              valid_q;
  logic              valid_d;
  logic              gs_n_q;
  logic              gs_n_d;
  logic              eo_n_q;
  logic              eo_n_d;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_line
      req_encoder_8to3_sync_fall_det #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_det (
        .clk  (CLK),
        .rst  (RST),
        .req_n(I_n[gi]),
        .fall (fall[gi])
      );
    end
  endgenerate

  // Handshake FSM, pending-vector update and status outputs computed from next-state values.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    clr_vec = '0;
    set_vec = fall & {N_REQ{~EI_n}};

    case (state_q)
      ST_OFFER: begin
        // Code and VALID stay frozen until the consumer accepts, whatever else arrives.
        valid_d = 1'b1;
        if (ACK) begin
          clr_vec[code_q] = 1'b1;
          valid_d         = 1'b0;
          state_d         = ST_GAP;
        end
      end
      ST_GAP: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
        if (|pend_q) begin
          state_d = ST_OFFER;
          code_d  = highest_index(pend_q);
          valid_d = 1'b1;
        end
      end
    endcase

    // A new capture in the same cycle as its clear keeps the bit set.
    pend_d = (pend_q & ~clr_vec) | set_vec;
    gs_n_d = ~(~EI_n & (|pend_d));
    eo_n_d = ~(~EI_n & ~(|pend_d) & (state_d == ST_IDLE));
  end

  // State, pending vector and output registers; reset clears everything immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      gs_n_q  <= 1'b1;
      eo_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      gs_n_q  <= gs_n_d;
      eo_n_q  <= eo_n_d;
    end
  end

  assign {C, B, A} = code_q;
  assign VALID     = valid_q;
  assign GS_n      = gs_n_q;
  assign EO_n      = eo_n_q;
  assign PEND      = pend_q;

endmodule

// File: tb/tb_req_encoder_8to3.sv
// Testbench for req_encoder_8to3: directed scenario tasks plus a randomized
// run checked against a transaction-level reference model.
module tb_req_encoder_8to3;

  localparam int S = 2;

  logic       clk;
  logic       rst;
  logic       ei_n;
  logic [7:0] i_n;
  logic       ack;
  logic       c;
  logic       b;
  logic       a;
  logic       valid;
  logic       gs_n;
  logic       eo_n;
  logic [7:0] pend;

  int n_checks;
  int n_fail;

  // Reference model state
  bit [7:0]   m_pend;
  bit         m_offer;
  bit         m_gap;
  bit         m_valid;
  bit [2:0]   m_code;
  bit         m_gs_n;
  bit         m_eo_n;
  logic [7:0] m_hist[$];

  req_encoder_8to3 #(.SYNC_STAGES(S)) dut (
    .CLK  (clk),
    .RST  (rst),
    .EI_n (ei_n),
    .I_n  (i_n),
    .ACK  (ack),
    .C    (c),
    .B    (b),
    .A    (a),
    .VALID(valid),
    .GS_n (gs_n),
    .EO_n (eo_n),
    .PEND (pend)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_pend  = '0;
    m_offer = 1'b0;
    m_gap   = 1'b0;
    m_valid = 1'b0;
    m_code  = '0;
    m_gs_n  = 1'b1;
    m_eo_n  = 1'b1;
    m_hist.delete();
  endtask

  // One clock edge of the reference: a request is captured S edges after the
  // sample that first shows it low, provided the sample before was high and
  // both samples were taken after reset.
  task automatic model_step();
    bit [7:0] fall_v;
    bit [7:0] clr;
    fall_v = '0;
    clr    = '0;
    m_hist.push_back(i_n);
    if (m_hist.size() > S + 2) void'(m_hist.pop_front());
    if (m_hist.size() == S + 2) fall_v = m_hist[0] & ~m_hist[1];
    if (m_offer) begin
      if (ack) begin
        clr[m_code] = 1'b1;
        m_offer = 1'b0;
        m_gap   = 1'b1;
        m_valid = 1'b0;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_pend != 0) begin
      m_offer = 1'b1;
      m_valid = 1'b1;
      for (int k = 7; k >= 0; k--) begin
        if (m_pend[k]) begin
          m_code = 3'(k);
          break;
        end
      end
    end
    m_pend = (m_pend & ~clr) | (ei_n ? 8'h00 : fall_v);
    m_gs_n = !(!ei_n && m_pend != 0);
    m_eo_n = !(!ei_n && m_pend == 0 && !m_offer && !m_gap);
  endtask

  // Advance one edge, update the model, and leave time 1 unit past the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (valid !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    ei_n = 1'b0;
    ack  = 1'b0;
    i_n  = 8'h00;
    repeat (3) tick();
    n_checks++;
    if (valid !== 1'b0 || pend !== 8'h00 || gs_n !== 1'b1 || eo_n !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_values: got valid=%b pend=%h gs_n=%b eo_n=%b, expected 0 00 1 1",
               valid, pend, gs_n, eo_n);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (pend !== 8'h00 || valid !== 1'b0 || gs_n !== 1'b1 || eo_n !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_release cycle %0d: got pend=%h valid=%b gs_n=%b eo_n=%b, expected 00 0 1 0",
                 i, pend, valid, gs_n, eo_n);
      end
    end
  endtask

  task automatic test_single();
    i_n = 8'hFF;
    repeat (5) tick();
    i_n = 8'hFE;
    repeat (3) tick();
    n_checks++;
    if (pend !== 8'h01 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_edge3: got pend=%h valid=%b, expected 01 0", pend, valid);
    end
    tick();
    n_checks++;
    if (valid !== 1'b1 || {c, b, a} !== 3'b000 || gs_n !== 1'b0) begin
      n_fail++;
      $display("FAIL single_edge4: got valid=%b code=%b gs_n=%b, expected 1 000 0",
               valid, {c, b, a}, gs_n);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++;
    if (valid !== 1'b0 || pend !== 8'h00) begin
      n_fail++;
      $display("FAIL single_ack: got valid=%b pend=%h, expected 0 00", valid, pend);
    end
    tick();
    n_checks++;
    if (eo_n !== 1'b0) begin
      n_fail++;
      $display("FAIL single_eo_n: got %b, expected 0", eo_n);
    end
    i_n = 8'hFF;
    repeat (4) tick();
  endtask

  task automatic test_multi();
    bit [2:0] exp_code[3];
    bit [7:0] exp_pend_before[3];
    bit [7:0] exp_pend_after[3];
    int cycles;
    exp_code        = '{3'd6, 3'd3, 3'd1};
    exp_pend_before = '{8'h4A, 8'h0A, 8'h02};
    exp_pend_after  = '{8'h0A, 8'h02, 8'h00};
    i_n = 8'hB5;
    wait_valid(cycles);
    n_checks++;
    if (cycles != 4) begin
      n_fail++;
      $display("FAIL multi_latency: got %0d edges, expected 4", cycles);
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        wait_valid(cycles);
        n_checks++;
        if (cycles != 2) begin
          n_fail++;
          $display("FAIL multi_spacing %0d: got %0d edges, expected 2", i, cycles);
        end
      end
      n_checks++;
      if ({c, b, a} !== exp_code[i] || pend !== exp_pend_before[i]) begin
        n_fail++;
        $display("FAIL multi_offer %0d: got code=%0d pend=%h, expected %0d %h",
                 i, {c, b, a}, pend, exp_code[i], exp_pend_before[i]);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      n_checks++;
      if (pend !== exp_pend_after[i] || valid !== 1'b0) begin
        n_fail++;
        $display("FAIL multi_ack %0d: got pend=%h valid=%b, expected %h 0",
                 i, pend, valid, exp_pend_after[i]);
      end
    end
    i_n = 8'hFF;
    repeat (4) tick();
  endtask

  task automatic test_preempt();
    int cycles;
    i_n = 8'hFB;
    wait_valid(cycles);
    n_checks++;
    if (valid !== 1'b1 || {c, b, a} !== 3'b010) begin
      n_fail++;
      $display("FAIL preempt_first: got valid=%b code=%b, expected 1 010", valid, {c, b, a});
    end
    i_n = 8'h7B;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (valid !== 1'b1 || {c, b, a} !== 3'b010) begin
        n_fail++;
        $display("FAIL preempt_hold cycle %0d: got valid=%b code=%b, expected 1 010",
                 i, valid, {c, b, a});
      end
    end
    n_checks++;
    if (pend !== 8'h84) begin
      n_fail++;
      $display("FAIL preempt_pend: got %h, expected 84", pend);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    wait_valid(cycles);
    n_checks++;
    if (valid !== 1'b1 || {c, b, a} !== 3'b111) begin
      n_fail++;
      $display("FAIL preempt_next: got valid=%b code=%b, expected 1 111", valid, {c, b, a});
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    i_n = 8'hFF;
    repeat (4) tick();
  endtask

  task automatic test_refall();
    int cycles;
    i_n = 8'hDF;
    wait_valid(cycles);
    n_checks++;
    if (valid !== 1'b1 || {c, b, a} !== 3'b101) begin
      n_fail++;
      $display("FAIL refall_first: got valid=%b code=%b, expected 1 101", valid, {c, b, a});
    end
    i_n = 8'hFF;
    repeat (4) tick();
    i_n = 8'hDF;
    repeat (2) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++;
    if (pend[5] !== 1'b1 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL refall_set_wins: got pend=%h valid=%b, expected bit5 set and 0", pend, valid);
    end
    wait_valid(cycles);
    n_checks++;
    if (valid !== 1'b1 || {c, b, a} !== 3'b101 || cycles != 2) begin
      n_fail++;
      $display("FAIL refall_second: got valid=%b code=%b gap=%0d, expected 1 101 2",
               valid, {c, b, a}, cycles);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++;
    if (pend !== 8'h00) begin
      n_fail++;
      $display("FAIL refall_clear: got pend=%h, expected 00", pend);
    end
    i_n = 8'hFF;
    repeat (4) tick();
  endtask

  task automatic test_disable();
    ei_n = 1'b1;
    tick();
    for (int i = 0; i < 30; i++) begin
      i_n = 8'($urandom);
      tick();
      n_checks++;
      if (pend !== 8'h00 || gs_n !== 1'b1 || eo_n !== 1'b1 || valid !== 1'b0) begin
        n_fail++;
        $display("FAIL disable cycle %0d: got pend=%h gs_n=%b eo_n=%b valid=%b, expected 00 1 1 0",
                 i, pend, gs_n, eo_n, valid);
      end
    end
    i_n = 8'hFF;
    repeat (4) tick();
    ei_n = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (pend !== 8'h00 || eo_n !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_exit: got pend=%h eo_n=%b, expected 00 0", pend, eo_n);
    end
  endtask

  task automatic test_async_reset();
    int cycles;
    i_n = 8'hEF;
    wait_valid(cycles);
    n_checks++;
    if (valid !== 1'b1 || {c, b, a} !== 3'b100) begin
      n_fail++;
      $display("FAIL async_offer: got valid=%b code=%b, expected 1 100", valid, {c, b, a});
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (valid !== 1'b0 || {c, b, a} !== 3'b000 || pend !== 8'h00 || gs_n !== 1'b1 || eo_n !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b code=%b pend=%h gs_n=%b eo_n=%b, expected 0 000 00 1 1",
               valid, {c, b, a}, pend, gs_n, eo_n);
    end
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (pend !== 8'h00 || valid !== 1'b0) begin
        n_fail++;
        $display("FAIL async_no_recover cycle %0d: got pend=%h valid=%b, expected 00 0", i, pend, valid);
      end
    end
    i_n = 8'hFF;
    repeat (4) tick();
  endtask

  task automatic test_random();
    rst  = 1'b1;
    ack  = 1'b0;
    ei_n = 1'b0;
    i_n  = 8'($urandom);
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 5) == 0) i_n[k] = ~i_n[k];
      end
      ei_n = ($urandom_range(0, 9) == 0);
      ack  = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if (valid !== m_valid || pend !== m_pend || gs_n !== m_gs_n || eo_n !== m_eo_n ||
          (m_valid && {c, b, a} !== m_code)) begin
        n_fail++;
        $display("FAIL random cycle %0d: got valid=%b code=%0d pend=%h gs_n=%b eo_n=%b, expected %b %0d %h %b %b",
                 i, valid, {c, b, a}, pend, gs_n, eo_n, m_valid, m_code, m_pend, m_gs_n, m_eo_n);
      end
    end
    ack  = 1'b0;
    ei_n = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    ei_n = 1'b0;
    ack  = 1'b0;
    i_n  = 8'h00;
    model_reset();
    test_reset();
    test_single();
    test_multi();
    test_preempt();
    test_refall();
    test_disable();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
